// File: rtl/lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
// Imported by the lane-steering helper and the LSU top.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_MEM_LATENCY = 7;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LOAD_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, load extension and misalignment/funct3 checks.
// Purely combinational; the LSU top registers everything it produces.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] drdata,
    output logic [3:0]  dwe,
    output logic [31:0] dwdata,
    output logic [31:0] ldata,
    output logic        fault
);

    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0])
                     || ((funct3[1:0] == 2'b10) && (addr != 2'b00));
    assign fault = illegal || misaligned;

    always_comb begin
        dwe    = 4'b0000;
        dwdata = 32'h0;
        if (is_store && !fault) begin
            case (funct3)
                F3_B: begin
                    dwe    = 4'b0001 << addr;
                    dwdata = {4{wdata[7:0]}};
                end
                F3_H: begin
                    dwe    = 4'b0011 << {addr[1], 1'b0};
                    dwdata = {2{wdata[15:0]}};
                end
                F3_W: begin
                    dwe    = 4'b1111;
                    dwdata = wdata;
                end
                default: begin
                    dwe    = 4'b0000;
                    dwdata = 32'h0;
                end
            endcase
        end
    end

    assign shifted = drdata >> {addr, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = addr[1] ? drdata[31:16] : drdata[15:0];

    always_comb begin
        ldata = 32'h0;
        case (funct3)
            F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ldata = {24'h0, lane_b};
            F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ldata = {16'h0, lane_h};
            F3_W:    ldata = drdata;
            default: ldata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: sequences one memory request per transaction
// and stalls the single-cycle core while the access is in flight.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memread,
    input  logic [3:0]  memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        stall,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    output logic        dre,
    input  logic [31:0] drdata
);

    localparam int LAT = (MEM_LATENCY < 1) ? 1
                       : (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY
                       : MEM_LATENCY;
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_q;

    logic        is_load;
    logic        is_store;
    logic        a_store;
    logic [2:0]  a_funct3;
    logic [1:0]  a_addr;
    logic [3:0]  al_dwe;
    logic [31:0] al_dwdata;
    logic [31:0] al_ldata;
    logic        al_fault;

    assign is_load  = memread;
    assign is_store = !memread && (memwrite != 4'b0000);

    // Live request fields in IDLE, captured ones while a load is waiting.
    assign a_store  = (state == IDLE) && is_store;
    assign a_funct3 = (state == IDLE) ? funct3 : funct3_q;
    assign a_addr   = (state == IDLE) ? addr[1:0] : addr_q;

    lsu_align u_align (
        .is_store (a_store),
        .funct3   (a_funct3),
        .addr     (a_addr),
        .wdata    (wdata),
        .drdata   (drdata),
        .dwe      (al_dwe),
        .dwdata   (al_dwdata),
        .ldata    (al_ldata),
        .fault    (al_fault)
    );

    assign stall = (state == STORE) || (state == LOAD_WAIT)
                || ((state == IDLE) && req_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'h0;
            fault      <= 1'b0;
            dwe        <= 4'b0000;
            dre        <= 1'b0;
            dwdata     <= 32'h0;
            daddr      <= 32'h0;
            cnt        <= 3'd0;
            funct3_q   <= F3_B;
            addr_q     <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= funct3;
                        addr_q    <= addr[1:0];
                        daddr     <= {addr[31:2], 2'b00};
                        req_ready <= 1'b0;
                        if (!is_load && !is_store) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            rdata      <= 32'h0;
                            fault      <= 1'b0;
                        end else if (al_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            rdata      <= 32'h0;
                            fault      <= 1'b1;
                        end else if (is_load) begin
                            state <= LOAD_WAIT;
                            dre   <= 1'b1;
                            cnt   <= CNT_INIT;
                        end else begin
                            state  <= STORE;
                            dwe    <= al_dwe;
                            dwdata <= al_dwdata;
                        end
                    end
                end
                STORE: begin
                    state      <= RESP;
                    dwe        <= 4'b0000;
                    dwdata     <= 32'h0;
                    resp_valid <= 1'b1;
                    rdata      <= 32'h0;
                    fault      <= 1'b0;
                end
                LOAD_WAIT: begin
                    if (cnt == 3'd0) begin
                        state      <= RESP;
                        dre        <= 1'b0;
                        resp_valid <= 1'b1;
                        rdata      <= al_ldata;
                        fault      <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
